counter_converter: RTL and testbench
====================================

COUNTER_CONVERTER -- requirements
Module: counter_converter

Interface
REQ-001 Parameter pHi, default 7, MSB index of the internal counter; counter width = pHi+1 bits.
REQ-002 Parameter pPad, default 16, number of pad bits added above the counter; output width = pHi+pPad+1 bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Clock  input  1  sole clock; all state changes on rising edge.
REQ-005 CountReset  input  1  asynchronous, active-low reset of the counter.
REQ-006 CountEnable  input  1  high = counter advances on the rising Clock edge.
REQ-007 OutEnable  input  1  high = counter value presented on Count.
REQ-008 Count  output  pHi+pPad+1  zero-extended counter value, gated by OutEnable.

Function
REQ-009 The block SHALL contain an internal (pHi+1)-bit unsigned counter register as its only state.
REQ-010 On a rising Clock edge with CountReset=1 and CountEnable=1, the counter SHALL increment by 1.
REQ-011 On a rising Clock edge with CountEnable=0, the counter SHALL hold its value.
REQ-012 The increment SHALL be modulo 2^(pHi+1): all-ones + 1 wraps to 0, with no carry-out or flag.
REQ-013 The output path SHALL be combinational, with no clock and no added latency.
REQ-014 With OutEnable=1: Count[pHi:0] = counter and Count[pHi+pPad:pHi+1] = 0.
REQ-015 With OutEnable=0: Count SHALL be driven to all zeros, not high-Z.
REQ-016 OutEnable SHALL never affect the counter; counting continues while the output is gated off.
REQ-017 Count SHALL change within the same time step as any change of OutEnable or the counter.
REQ-018 Reset SHALL take priority over CountEnable on every edge.
REQ-019 pPad=0 SHALL be legal: Count then equals the counter when OutEnable=1.
REQ-020 Counter value is visible only through Count; no other status outputs exist.

Reset
REQ-021 CountReset=0 SHALL clear the counter to 0 immediately, without a Clock edge.
REQ-022 The counter SHALL stay 0 while CountReset=0, regardless of Clock and CountEnable.
REQ-023 Reset value of Count SHALL be all zeros, whatever the level of OutEnable.
REQ-024 After CountReset returns to 1, the first enabled rising edge SHALL produce counter = 1.
REQ-025 Reset asserted mid-count SHALL discard the count; no partial or pending increment survives.
REQ-026 Counter value before the first reset is undefined; the bench SHALL reset first.

Verification (pHi=7, pPad=3, Count 11 bits)
REQ-027 Scenario 1: CountReset pulsed low with no Clock edge -> Count = 11'h000 immediately.
REQ-028 Scenario 2: after reset, CountEnable=1, OutEnable=1, two rising edges -> Count = 11'h002.
REQ-029 Scenario 3: OutEnable=0 during one edge -> Count = 0; OutEnable back to 1 -> Count = 11'h003, proving the counter kept counting.
REQ-030 Scenario 4: counter at 8'hFF, one enabled edge -> Count = 11'h000, bits [10:8] always 0.
REQ-031 Scenario 5: CountEnable=0 over three edges at value 5 -> Count stays 11'h005.
REQ-032 Scenario 6: CountReset driven low between edges at value 9 -> Count = 0 at once; after release, one enabled edge -> Count = 11'h001.

Source files
------------

// File: rtl/counter_converter.sv
// counter_converter
//   Free-running (pHi+1)-bit up counter presented as a zero-extended,
//   output-gated word of pHi+pPad+1 bits.
//
// Parameters
//   pHi   MSB index of the internal counter (counter width = pHi+1)
//   pPad  zero pad bits above the counter (output width = pHi+pPad+1)
//
// Ports
//   Clock        sole clock, rising-edge active
//   CountReset   asynchronous active-low clear of the counter
//   CountEnable  high: counter advances by one on the rising Clock edge
//   OutEnable    high: counter value is driven on Count; low: Count = 0
//   Count        zero-extended counter value, combinationally gated
module counter_converter #(
    parameter int pHi  = 7,
    parameter int pPad = 16
) (
    input  logic              Clock,
    input  logic              CountReset,
    input  logic              CountEnable,
    input  logic              OutEnable,
    output logic [pHi+pPad:0] Count
);

    localparam int CW = pHi + 1;

    logic [CW-1:0] counter;

    // Wraps modulo 2^CW; reset has priority over enable.
    always_ff @(posedge Clock or negedge CountReset) begin
        if (!CountReset) begin
            counter <= '0;
        end else if (CountEnable) begin
            counter <= counter + CW'(1);
        end
    end

    // Default-then-overwrite keeps pPad = 0 legal (no reversed pad slice).
    always_comb begin
        Count = '0;
        if (OutEnable) begin
            Count[pHi:0] = counter;
        end
    end

endmodule

// File: tb/tb_counter_converter.sv
// tb_counter_converter
//   Directed bench for counter_converter with pHi=7, pPad=3 (11-bit Count).
//   Expected values are queued when stimulus is applied and popped when
//   Count is sampled (always away from the rising edge).
module tb_counter_converter;

    logic        Clock;
    logic        CountReset;
    logic        CountEnable;
    logic        OutEnable;
    logic [10:0] Count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [10:0] sb[$];

    counter_converter #(
        .pHi (7),
        .pPad(3)
    ) dut (
        .Clock      (Clock),
        .CountReset (CountReset),
        .CountEnable(CountEnable),
        .OutEnable  (OutEnable),
        .Count      (Count)
    );

    // One full clock period: rising edge at +5, falling at +10.
    task automatic tick();
        #5 Clock = 1'b1;
        #5 Clock = 1'b0;
    endtask

    task automatic push(input logic [10:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag);
        logic [10:0] want;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: got %h, scoreboard empty", tag, Count);
        end else begin
            want = sb.pop_front();
            assert (Count === want) else begin
                bad++;
                $error("FAIL %s: got %h want %h", tag, Count, want);
            end
        end
    endtask

    initial begin
        Clock       = 1'b0;
        CountReset  = 1'b1;
        CountEnable = 1'b0;
        OutEnable   = 1'b1;

        // Scenario 1: asynchronous clear with no clock edge.
        #3 CountReset = 1'b0;
        #1 push(11'h000); check("rst_async");
        OutEnable = 1'b0;
        #1 push(11'h000); check("rst_oe_low");
        OutEnable = 1'b1;

        // Reset dominates enable across clock edges.
        CountEnable = 1'b1;
        tick(); push(11'h000); check("rst_hold_1");
        tick(); push(11'h000); check("rst_hold_2");

        // Scenario 2: release, two enabled edges.
        #2 CountReset = 1'b1;
        tick(); push(11'h001); check("first_edge");
        tick(); push(11'h002); check("second_edge");

        // Scenario 3: output gated off while counting continues.
        OutEnable = 1'b0;
        #1 push(11'h000); check("gate_off_now");
        tick(); push(11'h000); check("gate_off_edge");
        OutEnable = 1'b1;
        #1 push(11'h003); check("gate_on_3");

        // Scenario 5: hold at 5 for three edges.
        tick(); push(11'h004); check("cnt_4");
        tick(); push(11'h005); check("cnt_5");
        CountEnable = 1'b0;
        tick(); push(11'h005); check("hold_1");
        tick(); push(11'h005); check("hold_2");
        tick(); push(11'h005); check("hold_3");

        // Scenario 6: mid-count reset at 9, then restart from 1.
        CountEnable = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            tick();
        end
        push(11'h009); check("cnt_9");
        #2 CountReset = 1'b0;
        #1 push(11'h000); check("mid_rst");
        #1 CountReset = 1'b1;
        tick(); push(11'h001); check("after_mid_rst");

        // Scenario 4: count up to all-ones, then wrap.
        for (int i = 2; i <= 255; i++) begin
            logic [10:0] v;
            v = 11'(i);
            tick(); push(v); check("ramp");
        end
        OutEnable = 1'b0;
        #1 push(11'h000); check("ff_gated");
        OutEnable = 1'b1;
        #1 push(11'h0FF); check("at_ff");
        tick(); push(11'h000); check("wrap");
        tick(); push(11'h001); check("post_wrap");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d leftover entries want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
